// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// Module   : alu_op_sequencer_pkg
// Brief    : Shared state encoding, ALU control codes and default widths
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  localparam int c_DEF_WIDTH  = 32;
  localparam int c_DEF_CTRL_W = 3;
  localparam int c_DEF_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_seq_ce_reg.sv
// ============================================================================
// Module   : seq_ce_reg
// Brief    : Clock-enabled register with asynchronous active-high clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_ce_reg
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Six-state sequencer driving operand/result register enables
//            around an external combinational ALU. Option: ALU_SEQ_ACCUM_EN
//            adds an accum input that chains the previous result into A.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH  = c_DEF_WIDTH,
  parameter int CTRL_W = c_DEF_CTRL_W,
  parameter int CNT_W  = c_DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [CTRL_W-1:0] alu_ctrl,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic              accum,
`endif
  input  logic [WIDTH-1:0]  alu_res,
  input  logic              alu_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl_q,
  output logic [WIDTH-1:0]  result,
  output logic              zero_q,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             w_ce_a;
  logic             w_ce_b;
  logic             w_ce_r;
  logic [WIDTH-1:0] w_a_d;
  logic [CNT_W-1:0] r_op_count;
  logic             r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ce_a = 1'b0;
    w_ce_b = 1'b0;
    w_ce_r = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_LOAD_A;
      ST_LOAD_A: begin
        w_ce_a = 1'b1;
        w_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        w_ce_b = 1'b1;
        w_next = ST_EXEC;
      end
      // ALU settles on the freshly loaded operands; nothing is captured here.
      ST_EXEC:   w_next = ST_WRITE;
      ST_WRITE: begin
        w_ce_r = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

`ifdef ALU_SEQ_ACCUM_EN
  logic r_accum;

  // accum is only meaningful at the edge that accepts start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accum <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_accum <= accum;
    end
  end

  assign w_a_d = r_accum ? result : op_a;
`else
  assign w_a_d = op_a;
`endif

  seq_ce_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .i_ce (w_ce_a),
    .i_d  (w_a_d),
    .o_q  (alu_a)
  );

  seq_ce_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .i_ce (w_ce_b),
    .i_d  (op_b),
    .o_q  (alu_b)
  );

  seq_ce_reg #(.WIDTH(CTRL_W)) u_reg_ctrl (
    .clk  (clk),
    .rst  (rst),
    .i_ce (w_ce_b),
    .i_d  (alu_ctrl),
    .o_q  (alu_ctrl_q)
  );

  seq_ce_reg #(.WIDTH(WIDTH)) u_reg_res (
    .clk  (clk),
    .rst  (rst),
    .i_ce (w_ce_r),
    .i_d  (alu_res),
    .o_q  (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero     <= 1'b0;
      r_op_count <= '0;
    end else if (w_ce_r) begin
      r_zero     <= alu_zero;
      r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero_q   = r_zero;
  assign op_count = r_op_count;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Scoreboard bench with a behavioural ALU and sequencer model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  op_a, op_b, alu_res, alu_a, alu_b, result;
  logic [CW-1:0] alu_ctrl, alu_ctrl_q;
  logic          accum;
  logic          alu_zero, zero_q, busy, done;
  logic [NW-1:0] op_count;

  alu_op_sequencer #(.WIDTH(W), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_ctrl   (alu_ctrl),
`ifdef ALU_SEQ_ACCUM_EN
    .accum      (accum),
`endif
    .alu_res    (alu_res),
    .alu_zero   (alu_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl_q (alu_ctrl_q),
    .result     (result),
    .zero_q     (zero_q),
    .busy       (busy),
    .done       (done),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [CW-1:0] c);
    case (c)
      c_ALU_AND: return a & b;
      c_ALU_OR:  return a | b;
      c_ALU_ADD: return a + b;
      c_ALU_SUB: return a - b;
      c_ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return '0;
    endcase
  endfunction

  // External combinational ALU.
  assign alu_res  = alu_fn(alu_a, alu_b, alu_ctrl_q);
  assign alu_zero = (alu_res == '0);

  typedef struct {
    logic [W-1:0]  res;
    logic          z;
    logic [NW-1:0] cnt;
    int unsigned   cyc;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  m_result = '0;
  int            m_ops    = 0;
  int            n_vec    = 0;
  int            n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a completed operation yields ALU(A,B) and bumps a wrapping count.
  task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [CW-1:0] c, input logic acc, input int unsigned dcyc);
    exp_t e;
    logic [W-1:0] av;
`ifdef ALU_SEQ_ACCUM_EN
    av = acc ? m_result : a;
`else
    av = a;
    if (acc) av = a;
`endif
    m_result = alu_fn(av, b, c);
    m_ops++;
    e.res = m_result;
    e.z   = (m_result == '0);
    e.cnt = NW'(m_ops % (1 << NW));
    e.cyc = dcyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("zero_q", 64'(zero_q), 64'(e.z));
        check("op_count", 64'(op_count), 64'(e.cnt));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // One operation; inputs are scrambled after their load edge and start is
  // toggled while busy, all of which the sequencer must ignore.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [CW-1:0] c, input logic acc);
    wait_idle();
    start = 1'b1; op_a = a; op_b = b; alu_ctrl = c; accum = acc;
    expect_op(a, b, c, acc, cyc + 5);
    @(negedge clk); start = 1'($urandom_range(0, 1)); accum = 1'($urandom_range(0, 1));
    @(negedge clk); start = 1'($urandom_range(0, 1)); op_a = $urandom;
    @(negedge clk); start = 1'($urandom_range(0, 1)); op_b = $urandom; alu_ctrl = CW'($urandom);
    @(negedge clk); start = 1'($urandom_range(0, 1));
    @(negedge clk); start = 1'($urandom_range(0, 1));
    @(negedge clk); start = 1'b0;
  endtask

  logic [CW-1:0] codes [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned  c0;
    codes = '{c_ALU_AND, c_ALU_OR, c_ALU_ADD, c_ALU_SUB, c_ALU_SLT};
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; alu_ctrl = '0; accum = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {alu_a, alu_b, result},  96'd0 >> 32);
    check("rst_status", {61'd0, zero_q, busy, done}, 64'd0);
    check("rst_ctrl_cnt", 64'({alu_ctrl_q, op_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset arriving while in LOAD_B aborts the operation.
    start = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; alu_ctrl = c_ALU_ADD;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("mid_alu_a_loaded", 64'(alu_a), 64'h0000_0000_DEAD_BEEF);
    rst = 1'b1;
    #1;
    check("mid_rst_ab", 64'({alu_a, alu_b}), 64'd0);
    check("mid_rst_res_cnt", 64'({result, op_count}), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    m_result = '0; m_ops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 64'(done), 64'd0);
    end

    run_op(32'h0000_0005, 32'h0000_0003, c_ALU_ADD, 1'b0);
`ifdef ALU_SEQ_ACCUM_EN
    run_op(32'h0000_0077, 32'h0000_0002, c_ALU_ADD, 1'b1);
`endif
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, c_ALU_SUB, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, c_ALU_SLT, 1'b0);

    // Continuous start: three back-to-back operations six cycles apart.
    wait_idle();
    ra = $urandom; rb = $urandom;
    c0 = cyc;
    start = 1'b1; op_a = ra; op_b = rb; alu_ctrl = c_ALU_ADD; accum = 1'b0;
    for (int i = 0; i < 3; i++) expect_op(ra, rb, c_ALU_ADD, 1'b0, c0 + 5 + 6 * i);
    repeat (17) @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // Random operations; enough to wrap the counter more than once.
    for (int i = 0; i < 36; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(ra, rb, codes[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
